// File: rtl/dechuff_bit_reader_pkg.sv
// Shared constants, stream token type and size clamp for the DecHuff bit reader.
package dechuff_bit_reader_pkg;

    localparam int BUF_W    = 32;
    localparam int PEEK_W   = 16;
    localparam int FILL_LIM = BUF_W - 8;
    localparam int CNT_W    = $clog2(BUF_W + 1);
    localparam int SZ_W     = $clog2(PEEK_W + 1);

    localparam logic       JPEG_FILL_BIT = 1'b1;
    localparam logic [7:0] UNSTUFF_MARK  = 8'hFF;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } tok_t;

    // Peek/advance requests larger than the output width are treated as PEEK_W.
    function automatic logic [SZ_W-1:0] clamp_sz(input logic [7:0] v);
        return (v > 8'(PEEK_W)) ? SZ_W'(PEEK_W) : v[SZ_W-1:0];
    endfunction

endpackage

// File: rtl/dechuff_bit_reader_if.sv
// Handshake bundle between the DecHuff page queues, the bit reader and the Huffman decoder.
interface dechuff_bit_reader_if;

    logic [7:0] filebyte_d;
    logic       filebyte_e;
    logic       filebyte_v;
    logic       filebyte_b;

    logic [7:0] reqSize_d;
    logic       reqSize_e;
    logic       reqSize_v;
    logic       reqSize_b;

    logic [7:0] advance_d;
    logic       advance_e;
    logic       advance_v;
    logic       advance_b;

    logic [dechuff_bit_reader_pkg::PEEK_W-1:0] bits_d;
    logic       bits_e;
    logic       bits_v;
    logic       bits_b;

    modport master (
        output filebyte_d, filebyte_e, filebyte_v, input filebyte_b,
        output reqSize_d,  reqSize_e,  reqSize_v,  input reqSize_b,
        output advance_d,  advance_e,  advance_v,  input advance_b,
        input  bits_d,     bits_e,     bits_v,     output bits_b
    );

    modport slave (
        input  filebyte_d, filebyte_e, filebyte_v, output filebyte_b,
        input  reqSize_d,  reqSize_e,  reqSize_v,  output reqSize_b,
        input  advance_d,  advance_e,  advance_v,  output advance_b,
        output bits_d,     bits_e,     bits_v,     input  bits_b
    );

endinterface

// File: rtl/dechuff_bitbuf_shift.sv
// Combinational datapath of the bit buffer: advance shift, fill-padded peek, byte append.
// Valid bits sit MSB-aligned; everything below count is zero.
module dechuff_bitbuf_shift
    import dechuff_bit_reader_pkg::*;
(
    input  logic [BUF_W-1:0]  bitbuf_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              adv_en_i,
    input  logic [SZ_W-1:0]   adv_n_i,
    input  logic [SZ_W-1:0]   peek_n_i,
    input  logic              app_en_i,
    input  logic [7:0]        app_byte_i,
    output logic [CNT_W-1:0]  cnt_adv_o,
    output logic [PEEK_W-1:0] peek_o,
    output logic [BUF_W-1:0]  bitbuf_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [CNT_W-1:0] adv_n;
    logic [CNT_W-1:0] rsh;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] filled;

    assign adv_n     = adv_en_i ? CNT_W'(adv_n_i) : '0;
    assign shifted   = bitbuf_i << adv_n;
    // Over-advance only happens after end of stream and simply empties the buffer.
    assign cnt_adv_o = (count_i >= adv_n) ? (count_i - adv_n) : '0;

    // Positions past the valid bits read as the JPEG fill bit; N=0 shifts everything out.
    assign filled = shifted | ({BUF_W{JPEG_FILL_BIT}} >> cnt_adv_o);
    assign rsh    = CNT_W'(BUF_W) - CNT_W'(peek_n_i);
    assign peek_o = PEEK_W'(filled >> rsh);

    assign bitbuf_o = app_en_i ? (shifted | ({app_byte_i, {(BUF_W-8){1'b0}}} >> cnt_adv_o))
                               : shifted;
    assign count_o  = app_en_i ? (cnt_adv_o + CNT_W'(8)) : cnt_adv_o;

endmodule

// File: rtl/dechuff_bit_reader.sv
// DecHuff bit reader: bytes in, right-aligned peek windows out, advance consumes bits.
// Optional JPEG_UNSTUFF_EN drops the 0x00 stuffed after a 0xFF byte.
module dechuff_bit_reader
    import dechuff_bit_reader_pkg::*;
(
    input  logic clock,
    input  logic reset,
    dechuff_bit_reader_if.slave bus
);

    logic [BUF_W-1:0]  bitbuf_q, bitbuf_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              eos_q, eos_d;
    logic              adv_done_q, adv_done_d;
    logic              out_full_q, out_full_d;
    logic [PEEK_W-1:0] out_data_q, out_data_d;
    logic              out_eos_q, out_eos_d;

    tok_t              fb_tok, req_tok, adv_tok;
    logic [SZ_W-1:0]   adv_n, req_n;
    logic              boundary;
    logic              fb_ok, adv_ok, req_ok;
    logic              fb_acc, adv_acc, req_acc;
    logic              drop, app_en;

    logic [CNT_W-1:0]  cnt_adv, sh_count;
    logic [BUF_W-1:0]  sh_buf;
    logic [PEEK_W-1:0] peek;

    assign fb_tok  = {bus.filebyte_d, bus.filebyte_e};
    assign req_tok = {bus.reqSize_d,  bus.reqSize_e};
    assign adv_tok = {bus.advance_d,  bus.advance_e};

    // End-of-stream tokens carry no size.
    assign adv_n = adv_tok.e ? '0 : clamp_sz(adv_tok.d);
    assign req_n = req_tok.e ? '0 : clamp_sz(req_tok.d);

    // The cycle after both streams ended is spent resetting for the next file.
    assign boundary = eos_q & adv_done_q;

    assign fb_ok   = !boundary && !eos_q && (count_q <= CNT_W'(FILL_LIM));
    assign adv_ok  = !boundary && ((count_q >= CNT_W'(adv_n)) || eos_q);
    assign adv_acc = bus.advance_v & adv_ok;
    // The peek sees the buffer after this cycle's advance.
    assign req_ok  = !boundary && (!out_full_q || !bus.bits_b)
                     && ((cnt_adv >= CNT_W'(req_n)) || eos_q);
    assign req_acc = bus.reqSize_v & req_ok;
    assign fb_acc  = bus.filebyte_v & fb_ok;
    assign app_en  = fb_acc & !fb_tok.e & !drop;

`ifdef JPEG_UNSTUFF_EN
    logic prev_ff_q, prev_ff_d;

    assign drop = prev_ff_q && (fb_tok.d == 8'h00);

    always_comb begin
        prev_ff_d = prev_ff_q;
        if (boundary)
            prev_ff_d = 1'b0;
        else if (fb_acc && !fb_tok.e)
            prev_ff_d = (fb_tok.d == UNSTUFF_MARK);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev_ff_q <= 1'b0;
        else       prev_ff_q <= prev_ff_d;
    end
`else
    assign drop = 1'b0;
`endif

    dechuff_bitbuf_shift u_shift (
        .bitbuf_i   (bitbuf_q),
        .count_i    (count_q),
        .adv_en_i   (adv_acc),
        .adv_n_i    (adv_n),
        .peek_n_i   (req_n),
        .app_en_i   (app_en),
        .app_byte_i (fb_tok.d),
        .cnt_adv_o  (cnt_adv),
        .peek_o     (peek),
        .bitbuf_o   (sh_buf),
        .count_o    (sh_count)
    );

    always_comb begin
        bitbuf_d   = sh_buf;
        count_d    = sh_count;
        eos_d      = eos_q | (fb_acc & fb_tok.e);
        adv_done_d = adv_done_q | (adv_acc & adv_tok.e);
        if (boundary) begin
            bitbuf_d   = '0;
            count_d    = '0;
            eos_d      = 1'b0;
            adv_done_d = 1'b0;
        end
    end

    // Output slot survives file boundaries; only reset discards it.
    always_comb begin
        out_full_d = out_full_q;
        out_data_d = out_data_q;
        out_eos_d  = out_eos_q;
        if (req_acc) begin
            out_full_d = 1'b1;
            out_data_d = req_tok.e ? '0 : peek;
            out_eos_d  = req_tok.e;
        end else if (out_full_q && !bus.bits_b) begin
            out_full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bitbuf_q   <= '0;
            count_q    <= '0;
            eos_q      <= 1'b0;
            adv_done_q <= 1'b0;
            out_full_q <= 1'b0;
            out_data_q <= '0;
            out_eos_q  <= 1'b0;
        end else begin
            bitbuf_q   <= bitbuf_d;
            count_q    <= count_d;
            eos_q      <= eos_d;
            adv_done_q <= adv_done_d;
            out_full_q <= out_full_d;
            out_data_q <= out_data_d;
            out_eos_q  <= out_eos_d;
        end
    end

    assign bus.filebyte_b = reset | ~fb_ok;
    assign bus.advance_b  = reset | ~adv_ok;
    assign bus.reqSize_b  = reset | ~req_ok;
    assign bus.bits_v     = out_full_q;
    assign bus.bits_d     = out_data_q;
    assign bus.bits_e     = out_eos_q;

endmodule

// File: doc/dechuff_bit_reader.md
Name: dechuff_bit_reader

Overview:
- Bit-level reader directly downstream of the DecHuff page input queues.
- Consumes the queued filebyte, reqSize and advance streams, each 8-bit data plus end-of-stream flag with valid/back-pressure handshake.
- Presents a right-aligned peek window of the next N bits of the entropy-coded segment to the Huffman decoder.
- Serves as the decoder's single source of coded bits.

Parameters:
- BUF_W, 32, bit-buffer width in bits
- PEEK_W, 16, maximum peek/advance size and output data width
- FILL_LIM, 24, byte accepted only while count <= FILL_LIM (BUF_W-8)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- filebyte_d  in  8  coded byte
- filebyte_e  in  1  end-of-stream token (data ignored)
- filebyte_v  in  1  token valid
- filebyte_b  out  1  back-pressure to filebyte queue
- reqSize_d  in  8  peek size N
- reqSize_e  in  1  end-of-stream token
- reqSize_v  in  1  valid
- reqSize_b  out  1  back-pressure
- advance_d  in  8  bits to consume
- advance_e  in  1  end-of-stream token
- advance_v  in  1  valid
- advance_b  out  1  back-pressure
- bits_d  out  16  peeked bits, right-aligned, upper bits zero
- bits_e  out  1  end-of-stream token
- bits_v  out  1  valid
- bits_b  in  1  downstream back-pressure

Behaviour:
- Transfer on any stream occurs when v=1 and b=0 in the same cycle.
- Reset: buf=0, count=0, eos_seen=0, out_full=0; bits_v=0, bits_d=0, bits_e=0; all *_b=1 while reset is high.
- Byte fill:
  - filebyte_b=0 iff !eos_seen and count <= FILL_LIM.
  - Accepted byte is appended below existing bits (MSB-first); count += 8.
  - Accepted filebyte_e sets eos_seen; count unchanged.
- Advance (one per cycle):
  - Effective n = min(advance_d, 16).
  - advance_b=0 iff count >= n or eos_seen.
  - Buffer shifts left by n; count -= n, saturating at 0 when eos_seen.
  - Accepted advance_e sets adv_done.
- Peek (one per cycle):
  - Effective N = min(reqSize_d, 16).
  - reqSize_b=0 iff output slot is free or draining this cycle, and (count >= N or eos_seen).
  - On accept: bits_d = top N bits of buffer; missing bits below count are filled with 1s (JPEG fill); N=0 gives 0.
  - Accepted reqSize_e: emits bits_e=1, bits_d=0.
- Simultaneous advance and reqSize acceptance: advance is applied first; the peek samples the post-advance buffer.
- Byte fill in the same cycle is appended after the shift.
- Output register:
  - Latency 1: reqSize accepted at cycle T gives bits_v=1 at T+1.
  - bits_d/bits_e held stable while bits_v=1 and bits_b=1.
- File boundary: when eos_seen and adv_done are both set, the next cycle clears buf, count and flags, and the block accepts a new file. out_full is unaffected.
- Reset mid-operation: all state clears immediately; any pending output token is discarded.

Optional Feature:
- Macro: JPEG_UNSTUFF_EN.
- Defined: a 0x00 byte accepted immediately after an accepted 0xFF byte is consumed but not appended (count unchanged).
  - Tracked with a 1-bit prev_ff register, cleared on reset and at file boundary.
- Undefined: all bytes appended raw; no prev_ff register.

Decomposition:
- Shared package holds:
  - constants BUF_W, PEEK_W, FILL_LIM
  - JPEG_FILL_BIT=1, UNSTUFF_MARK=8'hFF
  - stream token typedef {d[7:0], e}
- One natural sub-module: dechuff_bitbuf_shift.
  - Combinational extract/left-shift/append of the BUF_W buffer with count arithmetic.
  - Instantiated once; the parent holds the handshakes and output register.

Test Plan:
- Feed 0xA5,0x3C; reqSize 4 -> bits_d=0x000A; advance 4; reqSize 8 -> bits_d=0x0053; reqSize 0 -> 0x0000.
- Feed 0xFF,0x00,0x12; reqSize 16 -> 0xFF12 with JPEG_UNSTUFF_EN, 0xFF00 without.
- Feed 0x80 then filebyte_e; advance 1; reqSize 8 -> bits_d=0x0001 (7 zeros + one fill 1); advance 12 -> count saturates to 0, no stall.
- Hold bits_b=1 for 3 cycles with bits_v=1 -> bits_d stable, reqSize_b=1; release -> next peek issued the following cycle.
- Fill until count=32 -> filebyte_b=1; advance 8 -> filebyte_b=0 next cycle; reqSize 20 -> treated as 16.
- Assert reset mid-stream with bits_v=1 -> bits_v=0 immediately, all *_b=1; after release, fresh bytes 0x5A and reqSize 8 -> 0x005A.
